mem_port_arbiter64: RTL and testbench

- Shares one single-ported memory between the instruction-fetch requester and the load/store requester of the RV64 core.
- Allows one outstanding transaction at a time.
- Data requests have priority, and a starvation counter guarantees fetch progress.
- Grant and response pulses drive the core's i_mem_hazard / d_mem_issue_hazard / d_mem_recv_hazard generation.

---
 rtl/mem_port_arbiter64.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter64.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter64.sv
// mem_port_arbiter64: shares one single-ported memory between the fetch and
// load/store requesters of the RV64 core. Only one transaction is in flight.
// Data requests win ties; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data wins while fetch is waiting. A fetch redirect
// (i_flush) lets an in-flight fetch finish on the memory side but hides its
// grant and response from the core.

module mem_port_arbiter64_chk (
  input  logic clock,
  input  logic reset,
  input  logic in_wait,
  input  logic mem_rsp_valid
);
  // A memory response is only legal while a transaction is awaiting its reply.
  rsp_only_in_wait_a: assert property (@(posedge clock) disable iff (!reset)
    mem_rsp_valid |-> in_wait);
endmodule

module mem_port_arbiter64 #(
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [ADDRESS_BITS-1:0]   i_addr,
  input  logic                      i_flush,
  output logic                      i_gnt,
  output logic                      i_rsp_valid,
  output logic [DATA_WIDTH-1:0]     i_rsp_data,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDRESS_BITS-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
  output logic                      d_gnt,
  output logic                      d_rsp_valid,
  output logic [DATA_WIDTH-1:0]     d_rsp_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDRESS_BITS-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  input  logic                      mem_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic                      busy
);

  localparam int         BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic       OWN_FETCH  = 1'b0;
  localparam logic       OWN_DATA   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic [3:0]                starve_q, starve_d;
  logic                      drop_q, drop_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDRESS_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]       mem_byte_en_q, mem_byte_en_d;

  logic                      fetch_req_s;
  logic                      any_req_s;
  logic                      pick_data_s;
  logic                      arb_en_s;
  logic                      fetch_live_s;
  logic                      in_wait_s;

  // State and request-field registers; reset abandons any transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_FETCH;
      starve_q      <= 4'd0;
      drop_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {ADDRESS_BITS{1'b0}};
      mem_wdata_q   <= {DATA_WIDTH{1'b0}};
      mem_byte_en_q <= {BE_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      starve_q      <= starve_d;
      drop_q        <= drop_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
    end
  end

  // Next state: arbitration, starvation tracking, drop flag and field capture.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    starve_d      = starve_q;
    drop_d        = drop_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
    arb_en_s      = 1'b0;

    // A fetch raised together with a redirect is stale and never competes.
    fetch_req_s = i_req & ~i_flush;
    any_req_s   = fetch_req_s | d_req;
    pick_data_s = d_req & ~(fetch_req_s & (starve_q == STARVE_MAX));

    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          arb_en_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
        if ((owner_q == OWN_FETCH) && i_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          // Transaction ends here; re-arbitrate for back-to-back issue.
          drop_d = 1'b0;
          if (any_req_s) begin
            arb_en_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((owner_q == OWN_FETCH) && i_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arb_en_s) begin
      state_d = ST_ISSUE;
      if (pick_data_s) begin
        owner_d       = OWN_DATA;
        mem_we_d      = d_we;
        mem_addr_d    = d_addr;
        mem_wdata_d   = d_wdata;
        mem_byte_en_d = d_byte_en;
        if (!i_req) begin
          starve_d = 4'd0;
        end else if (starve_q < STARVE_MAX) begin
          starve_d = starve_q + 4'd1;
        end else begin
          starve_d = STARVE_MAX;
        end
      end else begin
        owner_d       = OWN_FETCH;
        mem_we_d      = 1'b0;
        mem_addr_d    = i_addr;
        mem_wdata_d   = {DATA_WIDTH{1'b0}};
        mem_byte_en_d = {BE_WIDTH{1'b1}};
        starve_d      = 4'd0;
      end
    end else begin
      owner_d = owner_q;
    end

    mem_req_d = (state_d == ST_ISSUE);
  end

  // Outputs: grant on acceptance, response on reply, fetch side gated by drop.
  always_comb begin
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rsp_valid  = 1'b0;
    d_rsp_valid  = 1'b0;
    i_rsp_data   = {DATA_WIDTH{1'b0}};
    d_rsp_data   = {DATA_WIDTH{1'b0}};
    fetch_live_s = ~drop_q & ~i_flush;

    if ((state_q == ST_ISSUE) && mem_ready) begin
      if (owner_q == OWN_DATA) begin
        d_gnt = 1'b1;
      end else begin
        i_gnt = fetch_live_s;
      end
    end else begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end

    if ((state_q == ST_WAIT) && mem_rsp_valid) begin
      if (owner_q == OWN_DATA) begin
        d_rsp_valid = 1'b1;
        d_rsp_data  = mem_rsp_data;
      end else if (fetch_live_s) begin
        i_rsp_valid = 1'b1;
        i_rsp_data  = mem_rsp_data;
      end else begin
        i_rsp_valid = 1'b0;
        i_rsp_data  = {DATA_WIDTH{1'b0}};
      end
    end else begin
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
    end

    busy = (state_q != ST_IDLE);
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byte_en = mem_byte_en_q;
  assign in_wait_s   = (state_q == ST_WAIT);

  mem_port_arbiter64_chk u_chk (
    .clock         (clock),
    .reset         (reset),
    .in_wait       (in_wait_s),
    .mem_rsp_valid (mem_rsp_valid)
  );

endmodule

// File: tb/tb_mem_port_arbiter64.sv
// Bench for mem_port_arbiter64: behavioural requesters and memory, scoreboard
// queues of expected grants/responses, an arbitration vector table and
// directed multi-cycle sequences.

module tb_mem_port_arbiter64;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clock, reset;
  logic          i_req, i_flush, i_gnt, i_rsp_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rsp_data;
  logic          d_req, d_we, d_gnt, d_rsp_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rsp_data;
  logic [BW-1:0] d_byte_en;
  logic          mem_req, mem_we, mem_ready, mem_rsp_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rsp_data;
  logic [BW-1:0] mem_byte_en;

  mem_port_arbiter64 #(.ADDRESS_BITS(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_ready(mem_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic is_data; logic [AW-1:0] addr; } gnt_t;
  typedef struct { logic is_data; logic [DW-1:0] data; } rsp_t;
  typedef struct { logic i_req; logic i_flush; logic d_req; logic d_we;
                   logic exp_any; logic exp_data; } vec_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   checks = 0, errors = 0, cyc = 0;

  // requester model state
  logic          i_req_v, i_flush_v, d_req_v, d_we_v;
  logic [AW-1:0] i_addr_v, d_addr_v;
  logic [DW-1:0] d_wdata_v;
  logic [BW-1:0] d_be_v;
  int            i_rem, d_rem;
  // memory model state
  int            lat, stall, rsp_cnt;
  logic          rsp_pend, ovr_en;
  logic [DW-1:0] rsp_pend_data, ovr_val;
  // event timestamps
  int            last_i_gnt_cyc, last_d_rsp_cyc, first_gnt_cyc, last_gnt_cyc;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {12'hA5C, a, 12'h3B7, a ^ 20'hFFFFF};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_txn(input logic is_data, input logic [AW-1:0] a, input logic gnt_vis,
                         input logic rsp_vis, input logic [DW-1:0] data);
    gnt_t g;
    rsp_t r;
    g.is_data = is_data; g.addr = a;
    r.is_data = is_data; r.data = data;
    if (gnt_vis) gq.push_back(g);
    if (rsp_vis) rq.push_back(r);
  endtask

  // One clock cycle: drive at negedge, sample 2 time units later, update models.
  task automatic step();
    gnt_t g;
    rsp_t r;
    @(negedge clock);
    i_req = i_req_v; i_flush = i_flush_v; i_addr = i_addr_v;
    d_req = d_req_v; d_we = d_we_v; d_addr = d_addr_v; d_wdata = d_wdata_v; d_byte_en = d_be_v;
    mem_ready     = (stall == 0);
    mem_rsp_valid = rsp_pend && (rsp_cnt == 0);
    mem_rsp_data  = mem_rsp_valid ? rsp_pend_data : 64'hBAD0_BAD0_BAD0_BAD0;
    #2;
    chk1("gnt_exclusive", i_gnt & d_gnt, 1'b0);
    if (!i_rsp_valid) chkw("i_rsp_data_zero", i_rsp_data, 64'd0);
    if (!d_rsp_valid) chkw("d_rsp_data_zero", d_rsp_data, 64'd0);
    if (i_gnt || d_gnt) begin
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_gnt: i_gnt=%0b d_gnt=%0b none expected (cycle %0d)", i_gnt, d_gnt, cyc);
      end else begin
        g = gq.pop_front();
        chk1("gnt_port", d_gnt, g.is_data);
        chkw("gnt_addr", 64'(mem_addr), 64'(g.addr));
      end
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      last_gnt_cyc = cyc;
      if (i_gnt) last_i_gnt_cyc = cyc;
    end
    if (i_rsp_valid || d_rsp_valid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: i_rsp=%0b d_rsp=%0b none expected (cycle %0d)", i_rsp_valid, d_rsp_valid, cyc);
      end else begin
        r = rq.pop_front();
        chk1("rsp_port", d_rsp_valid, r.is_data);
        chkw("rsp_data", d_rsp_valid ? d_rsp_data : i_rsp_data, r.data);
      end
      if (d_rsp_valid) last_d_rsp_cyc = cyc;
    end
    // requesters hold until granted, optionally re-requesting at the next address
    if (i_gnt) begin
      if (i_rem > 1) begin i_rem--; i_addr_v += 20'h8; end
      else begin i_rem = 0; i_req_v = 1'b0; end
    end
    if (d_gnt) begin
      if (d_rem > 1) begin d_rem--; d_addr_v += 20'h8; end
      else begin d_rem = 0; d_req_v = 1'b0; end
    end
    // memory: accept on req&ready, respond lat cycles later
    if (mem_rsp_valid) rsp_pend = 1'b0;
    if (mem_req && mem_ready) begin
      rsp_pend = 1'b1; rsp_cnt = lat - 1;
      rsp_pend_data = ovr_en ? ovr_val : mem_fn(mem_addr);
    end else if (rsp_pend && rsp_cnt > 0) begin
      rsp_cnt--;
    end
    if (stall > 0) stall--;
    cyc++;
  endtask

  task automatic clear_models();
    i_req_v = 1'b0; i_flush_v = 1'b0; d_req_v = 1'b0; d_we_v = 1'b0;
    i_addr_v = 20'h0; d_addr_v = 20'h0; d_wdata_v = 64'h0; d_be_v = 8'h0;
    i_rem = 0; d_rem = 0; stall = 0; rsp_pend = 1'b0; rsp_cnt = 0; lat = 1;
    ovr_en = 1'b0; ovr_val = 64'h0; rsp_pend_data = 64'h0;
    gq.delete(); rq.delete();
    last_i_gnt_cyc = -1; last_d_rsp_cyc = -1; first_gnt_cyc = -1; last_gnt_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_models();
    step(); step();
    #1 reset = 1'b1;
  endtask

  task automatic run_idle(input string name);
    int n;
    n = 0;
    step();
    while (!(!busy && !i_req_v && !d_req_v && !rsp_pend && gq.size() == 0 && rq.size() == 0)
           && n < 200) begin
      step(); n++;
    end
    chk1({name, "_completes"}, n < 200, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   n;
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};  // fetch only
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};  // load only
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};  // store only
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};  // both: data first
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // flushed fetch ignored
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};  // flushed fetch + store
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // nothing

    // reset values before any clock edge
    reset = 1'b0; clear_models();
    i_req = 1'b0; i_flush = 1'b0; i_addr = 20'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 20'h0; d_wdata = 64'h0; d_byte_en = 8'h0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'h0;
    #3;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_mem_addr", 64'(mem_addr), 64'd0);
    chkw("rst_mem_wdata", mem_wdata, 64'd0);
    chkw("rst_mem_be", 64'(mem_byte_en), 64'd0);
    chk1("rst_mem_we", mem_we, 1'b0);

    // arbitration vector table
    for (int k = 0; k < 7; k++) begin
      do_reset();
      i_addr_v = 20'h01000 + 20'(k * 16);
      d_addr_v = 20'h02000 + 20'(k * 16);
      d_we_v = vt[k].d_we; d_wdata_v = 64'h0123_4567_89AB_CDEF; d_be_v = 8'hF0;
      i_req_v = vt[k].i_req; i_flush_v = vt[k].i_flush; i_rem = 1;
      d_req_v = vt[k].d_req; d_rem = 1;
      if (vt[k].exp_any) begin
        if (vt[k].exp_data) exp_txn(1'b1, d_addr_v, 1'b1, 1'b1, mem_fn(d_addr_v));
        else                exp_txn(1'b0, i_addr_v, 1'b1, 1'b1, mem_fn(i_addr_v));
        if (vt[k].exp_data && vt[k].i_req && !vt[k].i_flush)
          exp_txn(1'b0, i_addr_v, 1'b1, 1'b1, mem_fn(i_addr_v));
      end
      step();
      chk1("vec_arb_latency", mem_req, 1'b0);
      i_flush_v = 1'b0;
      if (vt[k].i_flush) i_req_v = 1'b0;
      step();
      chk1("vec_mem_req", mem_req, vt[k].exp_any);
      chk1("vec_busy", busy, vt[k].exp_any);
      if (vt[k].exp_any) begin
        chkw("vec_mem_addr", 64'(mem_addr),
             vt[k].exp_data ? 64'(20'h02000 + 20'(k * 16)) : 64'(20'h01000 + 20'(k * 16)));
        chk1("vec_mem_we", mem_we, vt[k].exp_data & vt[k].d_we);
      end
      run_idle("vec");
    end

    // fetch only, response two cycles after acceptance
    do_reset();
    lat = 2; ovr_en = 1'b1; ovr_val = 64'hDEADBEEF;
    i_addr_v = 20'h100; i_req_v = 1'b1; i_rem = 1;
    exp_txn(1'b0, 20'h100, 1'b1, 1'b1, 64'hDEADBEEF);
    step();
    chk1("f_c0_mem_req", mem_req, 1'b0);
    step();
    chk1("f_c1_mem_req", mem_req, 1'b1);
    chkw("f_c1_mem_addr", 64'(mem_addr), 64'h100);
    chk1("f_c1_i_gnt", i_gnt, 1'b1);
    step();
    chk1("f_c2_mem_req", mem_req, 1'b0);
    chk1("f_c2_busy", busy, 1'b1);
    chk1("f_c2_i_rsp", i_rsp_valid, 1'b0);
    step();
    chk1("f_c3_i_rsp", i_rsp_valid, 1'b1);
    chkw("f_c3_i_rsp_data", i_rsp_data, 64'hDEADBEEF);
    chk1("f_c3_d_rsp", d_rsp_valid, 1'b0);
    run_idle("fetch_only");
    ovr_en = 1'b0;

    // simultaneous requests: data first, fetch issued right after the data response
    do_reset();
    i_addr_v = 20'h200; i_req_v = 1'b1; i_rem = 1;
    d_addr_v = 20'h400; d_req_v = 1'b1; d_rem = 1; d_we_v = 1'b0;
    exp_txn(1'b1, 20'h400, 1'b1, 1'b1, mem_fn(20'h400));
    exp_txn(1'b0, 20'h200, 1'b1, 1'b1, mem_fn(20'h200));
    run_idle("simul");
    chkw("simul_no_gap", 64'(last_i_gnt_cyc), 64'(last_d_rsp_cyc + 1));

    // starvation: D,D,D,D,I,D,D,D,D,I at full throughput
    do_reset();
    i_addr_v = 20'h600; i_req_v = 1'b1; i_rem = 2;
    d_addr_v = 20'h800; d_req_v = 1'b1; d_rem = 8;
    for (int j = 0; j < 4; j++) exp_txn(1'b1, 20'h800 + 20'(j * 8), 1'b1, 1'b1, mem_fn(20'h800 + 20'(j * 8)));
    exp_txn(1'b0, 20'h600, 1'b1, 1'b1, mem_fn(20'h600));
    for (int j = 4; j < 8; j++) exp_txn(1'b1, 20'h800 + 20'(j * 8), 1'b1, 1'b1, mem_fn(20'h800 + 20'(j * 8)));
    exp_txn(1'b0, 20'h608, 1'b1, 1'b1, mem_fn(20'h608));
    run_idle("starve");
    chkw("throughput_span", 64'(last_gnt_cyc - first_gnt_cyc), 64'd18);

    // backpressure on a store
    do_reset();
    d_addr_v = 20'h80; d_we_v = 1'b1; d_wdata_v = 64'h1122334455667788; d_be_v = 8'hFF;
    d_req_v = 1'b1; d_rem = 1; stall = 4;
    exp_txn(1'b1, 20'h80, 1'b1, 1'b1, mem_fn(20'h80));
    step();
    for (int c = 1; c <= 3; c++) begin
      step();
      chk1("bp_mem_req", mem_req, 1'b1);
      chk1("bp_mem_we", mem_we, 1'b1);
      chkw("bp_mem_addr", 64'(mem_addr), 64'h80);
      chkw("bp_mem_wdata", mem_wdata, 64'h1122334455667788);
      chkw("bp_mem_be", 64'(mem_byte_en), 64'hFF);
      chk1("bp_no_gnt", d_gnt, 1'b0);
    end
    step();
    chk1("bp_gnt", d_gnt, 1'b1);
    step();
    chk1("bp_gnt_pulse", d_gnt, 1'b0);
    chk1("bp_req_drop", mem_req, 1'b0);
    run_idle("backpressure");

    // flush during fetch WAIT, then a normal load
    do_reset();
    lat = 2;
    i_addr_v = 20'h300; i_req_v = 1'b1; i_rem = 1;
    exp_txn(1'b0, 20'h300, 1'b1, 1'b0, 64'h0);
    step(); step();
    i_flush_v = 1'b1;
    step();
    i_flush_v = 1'b0;
    step();
    chk1("fw_rsp_suppressed", i_rsp_valid, 1'b0);
    chk1("fw_busy_at_rsp", busy, 1'b1);
    d_addr_v = 20'h500; d_we_v = 1'b0; d_req_v = 1'b1; d_rem = 1;
    exp_txn(1'b1, 20'h500, 1'b1, 1'b1, mem_fn(20'h500));
    run_idle("flush_wait");

    // flush during fetch ISSUE under backpressure, then a normal fetch
    do_reset();
    stall = 3;
    i_addr_v = 20'h340; i_req_v = 1'b1; i_rem = 1;
    step();
    i_flush_v = 1'b1; i_req_v = 1'b0;
    step();
    chk1("fi_c1_mem_req", mem_req, 1'b1);
    chk1("fi_c1_no_gnt", i_gnt, 1'b0);
    i_flush_v = 1'b0;
    step();
    chk1("fi_c2_mem_req", mem_req, 1'b1);
    step();
    chk1("fi_c3_mem_req", mem_req, 1'b1);
    chk1("fi_c3_gnt_suppressed", i_gnt, 1'b0);
    step();
    chk1("fi_c4_rsp_suppressed", i_rsp_valid, 1'b0);
    run_idle("flush_issue");
    i_addr_v = 20'h360; i_req_v = 1'b1; i_rem = 1;
    exp_txn(1'b0, 20'h360, 1'b1, 1'b1, mem_fn(20'h360));
    run_idle("after_flush");

    // async reset mid-WAIT, then starvation count restarts from zero
    do_reset();
    lat = 3;
    i_addr_v = 20'h700; i_req_v = 1'b1; i_rem = 1;
    d_addr_v = 20'h900; d_req_v = 1'b1; d_rem = 8;
    for (int j = 0; j < 3; j++) exp_txn(1'b1, 20'h900 + 20'(j * 8), 1'b1, 1'b1, mem_fn(20'h900 + 20'(j * 8)));
    n = 0;
    step();
    while (!(gq.size() == 0 && busy && !mem_req) && n < 100) begin step(); n++; end
    chk1("rst_reach_wait", n < 100, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk1("arst_mem_req", mem_req, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chkw("arst_mem_addr", 64'(mem_addr), 64'd0);
    chk1("arst_mem_we", mem_we, 1'b0);
    chk1("arst_i_gnt", i_gnt, 1'b0);
    chk1("arst_d_gnt", d_gnt, 1'b0);
    chk1("arst_d_rsp", d_rsp_valid, 1'b0);
    chkw("arst_d_rsp_data", d_rsp_data, 64'd0);
    clear_models();
    step(); step();
    #1 reset = 1'b1;
    i_addr_v = 20'hA00; i_req_v = 1'b1; i_rem = 1;
    d_addr_v = 20'hB00; d_req_v = 1'b1; d_rem = 4;
    for (int j = 0; j < 4; j++) exp_txn(1'b1, 20'hB00 + 20'(j * 8), 1'b1, 1'b1, mem_fn(20'hB00 + 20'(j * 8)));
    exp_txn(1'b0, 20'hA00, 1'b1, 1'b1, mem_fn(20'hA00));
    run_idle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
